temperature_poll_sequencer: RTL and testbench

Upstream controller for the TMP101 I2C read unit: it replaces the manual Start one-shot with an autonomous polling loop. It walks the enabled TMP101 chip addresses (A2..A0 = 0..7), issues one Go pulse per chip, waits for Done or a timeout, and captures each first-byte temperature. It also tracks signed min/max readings and feeds the selected reading to the Celsius/Fahrenheit converter and 7-segment path.

---
 rtl/temperature_poll_sequencer_if.sv | 26 ++
 rtl/temperature_poll_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_temperature_poll_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/temperature_poll_sequencer_if.sv
// Handshake between the poll sequencer and the TMP101 I2C read unit.
// The sequencer (master) issues Go with the chip address; the read unit
// (slave) answers with a Done edge and the first received byte.
interface temperature_poll_sequencer_if;
  logic       Go;
  logic [2:0] ChipSelect;
  logic [7:0] Chip;
  logic       Done;
  logic [7:0] ReceivedData;

  modport master (
    output Go,
    output ChipSelect,
    output Chip,
    input  Done,
    input  ReceivedData
  );

  modport slave (
    input  Go,
    input  ChipSelect,
    input  Chip,
    output Done,
    output ReceivedData
  );
endinterface

// File: rtl/temperature_poll_sequencer.sv
// Autonomous TMP101 polling loop: walks enabled chip addresses, issues one Go
// per chip, waits for a Done edge or a timeout, stores each temperature byte
// and tracks signed min/max across all stored readings.
module temperature_poll_sequencer #(
  parameter int unsigned PollCycles    = 8000000,
  parameter int unsigned TimeoutCycles = 400000
) (
  input  logic                                clock,
  input  logic                                Reset,
  input  logic                                Enable,
  input  logic [7:0]                          ChipEnable,
  input  logic [2:0]                          DisplaySelect,
  temperature_poll_sequencer_if.master        i2c,
  output logic [7:0]                          Temperature,
  output logic [7:0]                          MaxTemp,
  output logic [7:0]                          MinTemp,
  output logic [7:0]                          Valid,
  output logic [7:0]                          ErrorMask,
  output logic                                SweepDone,
  output logic                                Busy
);

  localparam int unsigned CountMax = (PollCycles > TimeoutCycles) ? PollCycles : TimeoutCycles;
  localparam int unsigned CW       = $clog2(CountMax + 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT_DONE,
    STORE,
    WAIT_PERIOD
  } state_t;

  state_t        state, state_d;
  // Pointer carries a fourth bit so that "one past chip 7" is representable
  // after a store/timeout on chip 7; SCAN then closes the sweep.
  logic [3:0]    ptr, ptr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    sel, sel_d;
  logic          sweep_d;
  logic          timeout_hit;
  logic          done_q;
  logic          done_rise;
  logic [7:0]    rx_data;
  logic [7:0]    readings [8];

  assign done_rise      = i2c.Done & ~done_q;
  assign i2c.Go         = (state == ISSUE);
  assign i2c.ChipSelect = sel;
  assign i2c.Chip       = {4'b1001, sel, 1'b1};
  assign Busy           = (state != IDLE);

  // Next-state, pointer, counter and chip-select selection.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    cnt_d       = cnt;
    sel_d       = sel;
    sweep_d     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        ptr_d = '0;
        if (Enable && (ChipEnable != '0)) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!Enable) begin
          ptr_d   = '0;
          state_d = IDLE;
        end else if (ptr[3]) begin
          sweep_d = 1'b1;
          ptr_d   = '0;
          cnt_d   = '0;
          state_d = WAIT_PERIOD;
        end else if (ChipEnable[ptr[2:0]]) begin
          sel_d   = ptr[2:0];
          state_d = ISSUE;
        end else if (ptr[2:0] == 3'd7) begin
          sweep_d = 1'b1;
          ptr_d   = '0;
          cnt_d   = '0;
          state_d = WAIT_PERIOD;
        end else begin
          ptr_d = ptr + 4'd1;
        end
      end
      ISSUE: begin
        // Counter holds cycles elapsed since Go, so the first WAIT_DONE cycle sees 1.
        cnt_d   = CW'(1);
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_d = cnt + CW'(1);
        if (done_rise) begin
          state_d = STORE;
        end else if (cnt == CW'(TimeoutCycles)) begin
          timeout_hit = 1'b1;
          ptr_d       = ptr + 4'd1;
          state_d     = Enable ? SCAN : IDLE;
        end
      end
      STORE: begin
        ptr_d   = ptr + 4'd1;
        state_d = Enable ? SCAN : IDLE;
      end
      WAIT_PERIOD: begin
        cnt_d = cnt + CW'(1);
        if (!Enable || (ChipEnable == '0)) begin
          state_d = IDLE;
        end else if (cnt == CW'(PollCycles - 1)) begin
          ptr_d   = '0;
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers, Done edge history and reply capture.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      sel       <= '0;
      SweepDone <= 1'b0;
      done_q    <= 1'b0;
      rx_data   <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      sel       <= sel_d;
      SweepDone <= sweep_d;
      done_q    <= i2c.Done;
      if ((state == WAIT_DONE) && done_rise) begin
        rx_data <= i2c.ReceivedData;
      end
    end
  end

  // Per-chip readings, status masks and signed extremes.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < 8; i++) begin
        readings[i] <= '0;
      end
      Valid     <= '0;
      ErrorMask <= '0;
      MaxTemp   <= 8'h80;
      MinTemp   <= 8'h7F;
    end else if (state == STORE) begin
      readings[ptr[2:0]]  <= rx_data;
      Valid[ptr[2:0]]     <= 1'b1;
      ErrorMask[ptr[2:0]] <= 1'b0;
      if (Valid == '0) begin
        MaxTemp <= rx_data;
        MinTemp <= rx_data;
      end else begin
        if ($signed(rx_data) > $signed(MaxTemp)) begin
          MaxTemp <= rx_data;
        end
        if ($signed(rx_data) < $signed(MinTemp)) begin
          MinTemp <= rx_data;
        end
      end
    end else if (timeout_hit) begin
      ErrorMask[ptr[2:0]] <= 1'b1;
    end
  end

  // Registered view of the reading selected for display.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      Temperature <= '0;
    end else begin
      Temperature <= readings[DisplaySelect];
    end
  end

endmodule

// File: tb/tb_temperature_poll_sequencer.sv
// Bench for temperature_poll_sequencer: a responder models the I2C read unit,
// a Go monitor checks issued addresses against a queue of expected chips.
module tb_temperature_poll_sequencer;
  localparam int unsigned POLL = 20;
  localparam int unsigned TMO  = 10;

  logic       clock;
  logic       Reset;
  logic       Enable;
  logic [7:0] ChipEnable;
  logic [2:0] DisplaySelect;
  logic [7:0] Temperature, MaxTemp, MinTemp, Valid, ErrorMask;
  logic       SweepDone, Busy;

  temperature_poll_sequencer_if bus ();

  temperature_poll_sequencer #(.PollCycles(POLL), .TimeoutCycles(TMO)) dut (
    .clock        (clock),
    .Reset        (Reset),
    .Enable       (Enable),
    .ChipEnable   (ChipEnable),
    .DisplaySelect(DisplaySelect),
    .i2c          (bus),
    .Temperature  (Temperature),
    .MaxTemp      (MaxTemp),
    .MinTemp      (MinTemp),
    .Valid        (Valid),
    .ErrorMask    (ErrorMask),
    .SweepDone    (SweepDone),
    .Busy         (Busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  logic [7:0] resp_data [8];
  int         resp_mode;   // 0 silent with timeout checks, 1 reply, 2 ignore
  logic       inject;
  int         go_count = 0;
  int         sd_count = 0;
  int         first_go = -1;

  typedef struct {
    logic [7:0] mask;
    int         mode;
    logic [7:0] valid;
    logic [7:0] err;
    logic [7:0] maxt;
    logic [7:0] mint;
  } sweep_vec_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] temp;
  } disp_vec_t;

  sweep_vec_t sweeps [4];
  disp_vec_t  disps  [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic responder();
    logic [2:0] ch;
    logic       v0, e0;
    bus.Done         = 1'b0;
    bus.ReceivedData = 8'h00;
    forever begin
      @(negedge clock);
      if (bus.Go && (resp_mode != 2)) begin
        ch = bus.ChipSelect;
        v0 = Valid[ch];
        e0 = ErrorMask[ch];
        if (resp_mode == 1) begin
          repeat (5) @(negedge clock);
          bus.Done         = 1'b1;
          bus.ReceivedData = resp_data[ch];
          @(negedge clock);
          bus.Done = 1'b0;
          check("valid_not_before_store", 32'(Valid[ch]), 32'(v0));
          @(negedge clock);
          check("valid_after_store", 32'(Valid[ch]), 'h1);
          check("error_cleared_by_store", 32'(ErrorMask[ch]), 'h0);
        end else begin
          repeat (10) @(negedge clock);
          check("timeout_not_early", 32'(ErrorMask[ch]), 32'(e0));
          @(negedge clock);
          check("timeout_error_set", 32'(ErrorMask[ch]), 'h1);
          check("timeout_valid_kept", 32'(Valid[ch]), 32'(v0));
        end
      end else begin
        bus.Done         = inject;
        bus.ReceivedData = inject ? 8'h55 : 8'h00;
      end
    end
  endtask

  task automatic go_monitor();
    logic       go_prev;
    logic [2:0] e;
    go_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (SweepDone) sd_count++;
      if (bus.Go) begin
        go_count++;
        if (first_go < 0) first_go = cyc;
        check("go_single_cycle", 32'(go_prev), 'h0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL go_unexpected: Go with ChipSelect %0d, required no Go (cycle %0d)", bus.ChipSelect, cyc);
        end else begin
          e = exp_q.pop_front();
          check("go_chipselect", 32'(bus.ChipSelect), 32'(e));
          check("go_chip_byte", 32'(bus.Chip), 32'({4'b1001, e, 1'b1}));
        end
      end
      go_prev = bus.Go;
    end
  endtask

  task automatic wait_sweep(input string name, output int at);
    at = -1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      if (SweepDone) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL %s: got no SweepDone expected one within 600 cycles", name);
    end
  endtask

  task automatic wait_go(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      if (bus.Go) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: got no Go expected one within 600 cycles", name);
    end
  endtask

  task automatic push_mask(input logic [7:0] m);
    for (int b = 0; b < 8; b++) begin
      if (m[b]) exp_q.push_back(3'(b));
    end
  endtask

  initial begin
    int         at, prev_sd, low, g0, s0, busy_hits;
    logic [7:0] prev_t;

    Reset         = 1'b0;
    Enable        = 1'b0;
    ChipEnable    = 8'h00;
    DisplaySelect = 3'd0;
    resp_mode     = 2;
    inject        = 1'b0;
    for (int i = 0; i < 8; i++) resp_data[i] = 8'h00;
    resp_data[0] = 8'h19;
    resp_data[1] = 8'hF6;
    resp_data[2] = 8'h1E;
    resp_data[7] = 8'h7F;

    sweeps[0] = '{8'h05, 1, 8'h05, 8'h00, 8'h1E, 8'h19};
    sweeps[1] = '{8'h02, 0, 8'h05, 8'h02, 8'h1E, 8'h19};
    sweeps[2] = '{8'h02, 1, 8'h07, 8'h00, 8'h1E, 8'hF6};
    sweeps[3] = '{8'h81, 1, 8'h87, 8'h00, 8'h7F, 8'hF6};

    disps[0] = '{3'd2, 8'h1E};
    disps[1] = '{3'd0, 8'h19};
    disps[2] = '{3'd1, 8'hF6};
    disps[3] = '{3'd7, 8'h7F};
    disps[4] = '{3'd3, 8'h00};
    disps[5] = '{3'd2, 8'h1E};

    fork
      responder();
      go_monitor();
    join_none

    repeat (3) @(negedge clock);
    check("rst_go", 32'(bus.Go), 'h0);
    check("rst_chipselect", 32'(bus.ChipSelect), 'h0);
    check("rst_chip", 32'(bus.Chip), 'h91);
    check("rst_sweepdone", 32'(SweepDone), 'h0);
    check("rst_busy", 32'(Busy), 'h0);
    check("rst_temperature", 32'(Temperature), 'h0);
    check("rst_valid", 32'(Valid), 'h0);
    check("rst_errormask", 32'(ErrorMask), 'h0);
    check("rst_maxtemp", 32'(MaxTemp), 'h80);
    check("rst_mintemp", 32'(MinTemp), 'h7F);

    Reset = 1'b1;
    @(negedge clock);

    // Table of sweeps; each entry is applied while the DUT is idle or waiting out a period.
    prev_sd = 0;
    for (int i = 0; i < 4; i++) begin
      ChipEnable = sweeps[i].mask;
      resp_mode  = sweeps[i].mode;
      Enable     = 1'b1;
      push_mask(sweeps[i].mask);
      first_go = -1;
      wait_sweep("sweep_done", at);
      if (i > 0) begin
        low = 0;
        for (int b = 7; b >= 0; b--) if (sweeps[i].mask[b]) low = b;
        check("poll_gap", 32'(first_go - prev_sd), 32'(POLL + 1 + low));
      end
      check("sweep_valid", 32'(Valid), 32'(sweeps[i].valid));
      check("sweep_errormask", 32'(ErrorMask), 32'(sweeps[i].err));
      check("sweep_maxtemp", 32'(MaxTemp), 32'(sweeps[i].maxt));
      check("sweep_mintemp", 32'(MinTemp), 32'(sweeps[i].mint));
      check("sweep_queue_drained", 32'(exp_q.size()), 'h0);
      prev_sd = at;
    end

    // Done pulse while waiting out the poll period must be ignored.
    resp_mode = 2;
    inject    = 1'b1;
    repeat (3) @(negedge clock);
    inject = 1'b0;
    repeat (2) @(negedge clock);
    Enable = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_after_disable", 32'(Busy), 'h0);
    check("inject_valid", 32'(Valid), 'h87);
    check("inject_maxtemp", 32'(MaxTemp), 'h7F);
    check("inject_mintemp", 32'(MinTemp), 'hF6);

    // Display selection table: registered, one cycle behind the select.
    prev_t = 8'h19;
    check("temp_initial", 32'(Temperature), 32'(prev_t));
    for (int i = 0; i < 6; i++) begin
      DisplaySelect = disps[i].sel;
      #1;
      check("temp_hold", 32'(Temperature), 32'(prev_t));
      @(negedge clock);
      check("temp_follow", 32'(Temperature), 32'(disps[i].temp));
      prev_t = disps[i].temp;
    end

    // Enable dropped two cycles after Go: the transaction completes, then idle.
    DisplaySelect = 3'd0;
    resp_data[0]  = 8'h20;
    resp_mode     = 1;
    ChipEnable    = 8'h05;
    exp_q.push_back(3'd0);
    g0 = go_count;
    s0 = sd_count;
    Enable = 1'b1;
    wait_go("disable_go");
    repeat (2) @(negedge clock);
    Enable = 1'b0;
    repeat (40) @(negedge clock);
    check("disable_go_count", 32'(go_count - g0), 'h1);
    check("disable_no_sweepdone", 32'(sd_count - s0), 'h0);
    check("disable_busy", 32'(Busy), 'h0);
    check("disable_stored", 32'(Temperature), 'h20);
    check("disable_queue_drained", 32'(exp_q.size()), 'h0);

    // Empty mask with Enable high: stays idle.
    ChipEnable = 8'h00;
    Enable     = 1'b1;
    g0         = go_count;
    busy_hits  = 0;
    repeat (200) begin
      @(negedge clock);
      if (Busy) busy_hits++;
    end
    check("empty_mask_busy_cycles", 32'(busy_hits), 'h0);
    check("empty_mask_go_count", 32'(go_count - g0), 'h0);

    // Reset asserted while waiting for Done on chip 2.
    resp_mode  = 2;
    ChipEnable = 8'h04;
    exp_q.push_back(3'd2);
    wait_go("reset_go");
    repeat (3) @(negedge clock);
    Reset = 1'b0;
    #1;
    check("async_rst_go", 32'(bus.Go), 'h0);
    check("async_rst_valid", 32'(Valid), 'h0);
    check("async_rst_maxtemp", 32'(MaxTemp), 'h80);
    check("async_rst_mintemp", 32'(MinTemp), 'h7F);
    check("async_rst_chipselect", 32'(bus.ChipSelect), 'h0);
    check("async_rst_chip", 32'(bus.Chip), 'h91);
    check("async_rst_busy", 32'(Busy), 'h0);
    @(negedge clock);
    Reset        = 1'b1;
    resp_data[0] = 8'h19;
    resp_mode    = 1;
    ChipEnable   = 8'h05;
    push_mask(8'h05);
    wait_sweep("restart_sweep", at);
    check("restart_valid", 32'(Valid), 'h05);
    check("restart_maxtemp", 32'(MaxTemp), 'h1E);
    check("restart_mintemp", 32'(MinTemp), 'h19);
    check("restart_errormask", 32'(ErrorMask), 'h0);
    check("restart_queue_drained", 32'(exp_q.size()), 'h0);

    Enable = 1'b0;
    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
